lcd_char_driver: RTL

- Drives a 16x2 HD44780-compatible character LCD over the 8-bit parallel bus, write-only.
- Runs the power-up init sequence, then refreshes both lines continuously.
- Walks a 5-bit character index 0..31 and consumes the registered character byte that the display-string block returns for each index.
- Sits between the display-string block and the LCD pins; that block is the data source, this block is the bus master.

---
 rtl/lcd_pkg.sv | 45 ++++
 rtl/lcd_byte_tx.sv | 108 ++++++++++
 rtl/lcd_char_driver.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/lcd_pkg.sv
// Shared types and constants for the HD44780 character LCD driver.
// Commands, FSM state encodings and display geometry.
package lcd_pkg;

  localparam logic [7:0] CMD_FUNC_SET = 8'h38;
  localparam logic [7:0] CMD_DISP_ON  = 8'h0C;
  localparam logic [7:0] CMD_ENTRY    = 8'h06;
  localparam logic [7:0] CMD_CLEAR    = 8'h01;
  localparam logic [7:0] CMD_LINE1    = 8'h80;
  localparam logic [7:0] CMD_LINE2    = 8'hC0;

  localparam int LCD_COLS  = 16;
  localparam int LCD_CHARS = 32;

  typedef enum logic [2:0] {
    PWRUP,
    INIT,
    ADDR,
    FETCH,
    WRITE,
    GAP
  } state_e;

  typedef enum logic [2:0] {
    TX_OFF,
    TX_SU,
    TX_PW,
    TX_H,
    TX_IDLE
  } tx_phase_e;

  function automatic logic [7:0] init_cmd(
    input logic [1:0] step
  );
    logic [7:0] c;
    unique case (step)
      2'd0: c = CMD_FUNC_SET;
      2'd1: c = CMD_DISP_ON;
      2'd2: c = CMD_ENTRY;
      2'd3: c = CMD_CLEAR;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/lcd_byte_tx.sv
// One HD44780 bus write: setup, enable pulse, hold, then idle.
// done pulses on the last idle clock; busy covers the whole transfer.
module lcd_byte_tx
  import lcd_pkg::*;
#(
  parameter int T_SU    = 4,
  parameter int T_PW    = 25,
  parameter int T_H     = 4,
  parameter int T_WAIT  = 2500,
  parameter int T_CLEAR = 100000,
  parameter int CNT_W   = 20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       rs,
  input  logic [7:0] data,
  input  logic       long_wait,
  output logic       lcd_e,
  output logic       lcd_rs,
  output logic [7:0] lcd_data,
  output logic       busy,
  output logic       done
);

  localparam logic [CNT_W-1:0] SU_LD = CNT_W'(T_SU - 1);
  localparam logic [CNT_W-1:0] PW_LD = CNT_W'(T_PW - 1);
  localparam logic [CNT_W-1:0] H_LD  = CNT_W'(T_H - 1);
  localparam logic [CNT_W-1:0] W_LD  = CNT_W'(T_WAIT - 1);
  localparam logic [CNT_W-1:0] C_LD  = CNT_W'(T_CLEAR - 1);

  tx_phase_e        phase_q;
  logic [CNT_W-1:0] cnt_q;
  logic             e_q;
  logic             rs_q;
  logic [7:0]       data_q;
  logic             long_q;
  logic             expired;

  assign expired = (cnt_q == '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      phase_q <= TX_OFF;
      cnt_q   <= '0;
      e_q     <= 1'b0;
      rs_q    <= 1'b0;
      data_q  <= '0;
      long_q  <= 1'b0;
    end else begin
      unique case (phase_q)
        TX_OFF: begin
          if (start) begin
            phase_q <= TX_SU;
            cnt_q   <= SU_LD;
            rs_q    <= rs;
            data_q  <= data;
            long_q  <= long_wait;
          end
        end
        TX_SU: begin
          if (expired) begin
            phase_q <= TX_PW;
            cnt_q   <= PW_LD;
            e_q     <= 1'b1;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        TX_PW: begin
          if (expired) begin
            phase_q <= TX_H;
            cnt_q   <= H_LD;
            e_q     <= 1'b0;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        TX_H: begin
          if (expired) begin
            phase_q <= TX_IDLE;
            cnt_q   <= long_q ? C_LD : W_LD;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        TX_IDLE: begin
          if (expired) begin
            phase_q <= TX_OFF;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        default: begin
          phase_q <= TX_OFF;
          e_q     <= 1'b0;
        end
      endcase
    end
  end

  assign lcd_e    = e_q;
  assign lcd_rs   = rs_q;
  assign lcd_data = data_q;
  assign busy     = (phase_q != TX_OFF);
  assign done     = (phase_q == TX_IDLE) && expired;

endmodule

// File: rtl/lcd_char_driver.sv
// 16x2 character LCD driver: power-up init, then continuous refresh
// of 32 characters fetched by index from a registered string source.
module lcd_char_driver
  import lcd_pkg::*;
#(
  parameter int T_PWRUP   = 750000,
  parameter int T_SU      = 4,
  parameter int T_PW      = 25,
  parameter int T_H       = 4,
  parameter int T_WAIT    = 2500,
  parameter int T_CLEAR   = 100000,
  parameter int T_REFRESH = 500000,
  parameter int CNT_W     = 20
) (
  input  logic       clk,
  input  logic       rst,
  output logic [4:0] index,
  input  logic [7:0] char_in,
  output logic       lcd_e,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic [7:0] lcd_data,
  output logic       init_done,
  output logic       frame_done
);

  localparam logic [CNT_W-1:0] PWR_LD = CNT_W'(T_PWRUP - 1);
  localparam logic [CNT_W-1:0] REF_LD = CNT_W'(T_REFRESH - 1);
  localparam logic [4:0] LAST_L1 = 5'(LCD_COLS - 1);
  localparam logic [4:0] LAST_L2 = 5'(LCD_CHARS - 1);

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [1:0]       step_q;
  logic             pend_q;
  logic             fetch_q;
  logic [4:0]       index_q;
  logic [7:0]       byte_q;
  logic             start_q;
  logic             tx_rs_q;
  logic [7:0]       tx_data_q;
  logic             tx_long_q;
  logic             init_done_q;
  logic             frame_done_q;

  logic tx_busy;
  logic tx_done;

  // pend_q marks a byte handed to the transmitter and not yet done;
  // in PWRUP it marks that the wait counter has been loaded.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= PWRUP;
      cnt_q        <= '0;
      step_q       <= '0;
      pend_q       <= 1'b0;
      fetch_q      <= 1'b0;
      index_q      <= '0;
      byte_q       <= '0;
      start_q      <= 1'b0;
      tx_rs_q      <= 1'b0;
      tx_data_q    <= '0;
      tx_long_q    <= 1'b0;
      init_done_q  <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      start_q      <= 1'b0;
      frame_done_q <= 1'b0;
      unique case (state_q)
        PWRUP: begin
          if (!pend_q) begin
            pend_q <= 1'b1;
            cnt_q  <= PWR_LD;
          end else if (cnt_q == '0) begin
            pend_q  <= 1'b0;
            step_q  <= '0;
            state_q <= INIT;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        INIT: begin
          if (!pend_q) begin
            if (!tx_busy) begin
              start_q   <= 1'b1;
              tx_rs_q   <= 1'b0;
              tx_data_q <= init_cmd(step_q);
              tx_long_q <= (step_q == 2'd3);
              pend_q    <= 1'b1;
            end
          end else if (tx_done) begin
            pend_q <= 1'b0;
            if (step_q == 2'd3) begin
              init_done_q <= 1'b1;
              state_q     <= ADDR;
            end else begin
              step_q <= step_q + 2'd1;
            end
          end
        end
        ADDR: begin
          if (!pend_q) begin
            if (!tx_busy) begin
              start_q   <= 1'b1;
              tx_rs_q   <= 1'b0;
              tx_data_q <= (index_q == '0) ? CMD_LINE1
                                           : CMD_LINE2;
              tx_long_q <= 1'b0;
              pend_q    <= 1'b1;
            end
          end else if (tx_done) begin
            pend_q  <= 1'b0;
            fetch_q <= 1'b0;
            state_q <= FETCH;
          end
        end
        FETCH: begin
          if (!fetch_q) begin
            fetch_q <= 1'b1;
          end else begin
            byte_q  <= char_in;
            state_q <= WRITE;
          end
        end
        WRITE: begin
          if (!pend_q) begin
            if (!tx_busy) begin
              start_q   <= 1'b1;
              tx_rs_q   <= 1'b1;
              tx_data_q <= byte_q;
              tx_long_q <= 1'b0;
              pend_q    <= 1'b1;
            end
          end else if (tx_done) begin
            pend_q <= 1'b0;
            if (index_q == LAST_L1) begin
              index_q <= index_q + 5'd1;
              state_q <= ADDR;
            end else if (index_q == LAST_L2) begin
              frame_done_q <= 1'b1;
              index_q      <= '0;
              cnt_q        <= REF_LD;
              state_q      <= GAP;
            end else begin
              index_q <= index_q + 5'd1;
              fetch_q <= 1'b0;
              state_q <= FETCH;
            end
          end
        end
        GAP: begin
          if (cnt_q == '0) begin
            state_q <= ADDR;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        default: state_q <= PWRUP;
      endcase
    end
  end

  lcd_byte_tx #(
    .T_SU    (T_SU),
    .T_PW    (T_PW),
    .T_H     (T_H),
    .T_WAIT  (T_WAIT),
    .T_CLEAR (T_CLEAR),
    .CNT_W   (CNT_W)
  ) u_tx (
    .clk       (clk),
    .rst       (rst),
    .start     (start_q),
    .rs        (tx_rs_q),
    .data      (tx_data_q),
    .long_wait (tx_long_q),
    .lcd_e     (lcd_e),
    .lcd_rs    (lcd_rs),
    .lcd_data  (lcd_data),
    .busy      (tx_busy),
    .done      (tx_done)
  );

  assign index      = index_q;
  assign lcd_rw     = 1'b0;
  assign init_done  = init_done_q;
  assign frame_done = frame_done_q;

endmodule
